mem_arbiter: RTL and testbench

//  Shares one mem_system instance between the instruction-fetch port (IF stage) and the

---
 rtl/mem_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates one mem_system between the fetch port (i_*) and the data port (d_*).
// Data wins by default; a starvation counter forces a fetch grant after STARVE_LIMIT data grants.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_rd,
  input  logic [15:0] i_addr,
  output logic [15:0] i_data_out,
  output logic        i_done,
  output logic        i_stall,
  input  logic        d_rd,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_data_in,
  output logic [15:0] d_data_out,
  output logic        d_done,
  output logic        d_stall,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data_in,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [15:0] mem_data_out,
  input  logic        mem_done,
  output logic        err
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE_I = 3'd1,
    S_WAIT_I  = 3'd2,
    S_ISSUE_D = 3'd3,
    S_WAIT_D  = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [SW-1:0] r_starve;
  logic [TW-1:0] r_tmo;
  logic [15:0]   r_addr;
  logic [15:0]   r_wdata;
  logic [15:0]   r_i_data;
  logic [15:0]   r_d_data;
  logic          r_wr;
  logic          r_cancel;
  logic          r_mem_rd;
  logic          r_mem_wr;
  logic          r_i_done;
  logic          r_d_done;
  logic          r_err;

  logic w_d_req;
  logic w_i_grant;
  logic w_d_grant;
  logic w_finish;
  logic w_timeout;
  logic w_req_live;
  logic w_deliver;
  logic w_on_i;
  logic w_on_d;

  assign w_d_req   = d_rd | d_wr;
  assign w_on_i    = (r_state == S_ISSUE_I) || (r_state == S_WAIT_I);
  assign w_on_d    = (r_state == S_ISSUE_D) || (r_state == S_WAIT_D);
  // A port that dropped its request at any point during its grant gets no done pulse.
  assign w_deliver = w_finish & w_req_live & ~r_cancel;

  assign i_data_out  = r_i_data;
  assign d_data_out  = r_d_data;
  assign i_done      = r_i_done;
  assign d_done      = r_d_done;
  assign i_stall     = i_rd & ~r_i_done;
  assign d_stall     = w_d_req & ~r_d_done;
  assign mem_addr    = r_addr;
  assign mem_data_in = r_wdata;
  assign mem_rd      = r_mem_rd;
  assign mem_wr      = r_mem_wr;
  assign err         = r_err;

  // Next-state and grant decode.
  always_comb begin
    w_next     = r_state;
    w_i_grant  = 1'b0;
    w_d_grant  = 1'b0;
    w_finish   = 1'b0;
    w_timeout  = 1'b0;
    w_req_live = 1'b0;
    case (r_state)
      S_IDLE: begin
        // A done cycle is skipped so the finishing port's still-high request is not re-granted.
        if (r_i_done || r_d_done) begin
          w_next = S_IDLE;
        end else if (w_d_req && (!i_rd || (r_starve < STARVE_MAX))) begin
          w_next    = S_ISSUE_D;
          w_d_grant = 1'b1;
        end else if (i_rd) begin
          w_next    = S_ISSUE_I;
          w_i_grant = 1'b1;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_ISSUE_I, S_WAIT_I: begin
        w_req_live = i_rd;
        if (mem_done) begin
          w_finish = 1'b1;
          w_next   = S_IDLE;
        end else if ((r_state == S_WAIT_I) && (r_tmo == TMO_LAST)) begin
          w_timeout = 1'b1;
          w_next    = S_IDLE;
        end else begin
          w_next = S_WAIT_I;
        end
      end
      S_ISSUE_D, S_WAIT_D: begin
        w_req_live = w_d_req;
        if (mem_done) begin
          w_finish = 1'b1;
          w_next   = S_IDLE;
        end else if ((r_state == S_WAIT_D) && (r_tmo == TMO_LAST)) begin
          w_timeout = 1'b1;
          w_next    = S_IDLE;
        end else begin
          w_next = S_WAIT_D;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // State, holding registers, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_starve <= SW'(0);
      r_tmo    <= TW'(0);
      r_addr   <= 16'h0000;
      r_wdata  <= 16'h0000;
      r_i_data <= 16'h0000;
      r_d_data <= 16'h0000;
      r_wr     <= 1'b0;
      r_cancel <= 1'b0;
      r_mem_rd <= 1'b0;
      r_mem_wr <= 1'b0;
      r_i_done <= 1'b0;
      r_d_done <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_mem_rd <= w_i_grant | (w_d_grant & ~d_wr);
      r_mem_wr <= w_d_grant & d_wr;
      r_i_done <= w_deliver & w_on_i;
      r_d_done <= w_deliver & w_on_d;

      if (w_i_grant) begin
        r_addr  <= i_addr;
        r_wdata <= 16'h0000;
        r_wr    <= 1'b0;
      end else if (w_d_grant) begin
        r_addr  <= d_addr;
        r_wdata <= d_data_in;
        r_wr    <= d_wr;
      end else if (w_next == S_IDLE) begin
        r_addr  <= 16'h0000;
        r_wdata <= 16'h0000;
      end

      if (w_i_grant || w_d_grant) begin
        r_cancel <= 1'b0;
      end else if ((r_state != S_IDLE) && !w_req_live) begin
        r_cancel <= 1'b1;
      end

      if (w_deliver && w_on_i) begin
        r_i_data <= mem_data_out;
      end
      if (w_deliver && w_on_d && !r_wr) begin
        r_d_data <= mem_data_out;
      end

      if (w_i_grant) begin
        r_starve <= SW'(0);
      end else if (w_d_grant && i_rd) begin
        if (r_starve != STARVE_MAX) begin
          r_starve <= r_starve + SW'(1);
        end
      end else if ((r_state == S_IDLE) && !i_rd) begin
        r_starve <= SW'(0);
      end

      if ((r_state == S_WAIT_I) || (r_state == S_WAIT_D)) begin
        r_tmo <= r_tmo + TW'(1);
      end else begin
        r_tmo <= TW'(0);
      end

      if (w_timeout || (d_rd && d_wr)) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a behavioural mem_system plus a scoreboard of expected done pulses.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        i_rd;
  logic [15:0] i_addr;
  logic [15:0] i_data_out;
  logic        i_done;
  logic        i_stall;
  logic        d_rd;
  logic        d_wr;
  logic [15:0] d_addr;
  logic [15:0] d_data_in;
  logic [15:0] d_data_out;
  logic        d_done;
  logic        d_stall;
  logic [15:0] mem_addr;
  logic [15:0] mem_data_in;
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] mem_data_out;
  logic        mem_done;
  logic        err;

  mem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst),
    .i_rd(i_rd), .i_addr(i_addr), .i_data_out(i_data_out), .i_done(i_done), .i_stall(i_stall),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_data_in(d_data_in),
    .d_data_out(d_data_out), .d_done(d_done), .d_stall(d_stall),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_data_out(mem_data_out), .mem_done(mem_done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        isd;
    logic        wr;
    logic [15:0] data;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] last_d   = 16'h0000;
  logic [15:0] mem_arr [logic [15:0]];
  int          mem_lat  = 1;
  bit          mem_hang = 1'b0;

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mem_val(input logic [15:0] a);
    if (mem_arr.exists(a)) return mem_arr[a];
    return a ^ 16'h5A5A;
  endfunction

  task automatic push(input logic isd, input logic wr, input logic [15:0] data);
    exp_t e;
    e.isd = isd; e.wr = wr; e.data = data;
    sb.push_back(e);
  endtask

  task automatic check_done(input logic isd, input logic [15:0] data);
    exp_t e;
    n_checks++;
    assert (sb.size() != 0) else begin
      n_errors++;
      $error("FAIL unexpected_done: observed done on port isd=%0d, expected none", isd);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk1("done_port", isd, e.isd);
      if (e.isd && e.wr) begin
        chk16("d_data_hold_after_write", data, last_d);
      end else begin
        chk16(isd ? "d_read_data" : "i_read_data", data, e.data);
        if (isd) last_d = e.data;
      end
    end
  endtask

  // Scoreboard pops on every done pulse.
  always @(negedge clk) begin
    if (i_done === 1'b1) check_done(1'b0, i_data_out);
    if (d_done === 1'b1) check_done(1'b1, d_data_out);
  end

  // Behavioural mem_system: answers mem_lat cycles after the issue cycle (0 = same cycle).
  initial begin
    bit          pend;
    int          p_cnt;
    logic [15:0] p_addr;
    logic [15:0] p_data;
    logic        p_wr;
    pend = 1'b0; p_cnt = 0; p_addr = 16'h0000; p_data = 16'h0000; p_wr = 1'b0;
    mem_done = 1'b0;
    mem_data_out = 16'hDEAD;
    forever begin
      @(posedge clk);
      #1;
      mem_done = 1'b0;
      mem_data_out = 16'hDEAD;
      if (rst) begin
        pend = 1'b0;
      end else begin
        if (mem_rd || mem_wr) begin
          pend = 1'b1; p_addr = mem_addr; p_data = mem_data_in; p_wr = mem_wr; p_cnt = mem_lat;
        end
        if (pend && !mem_hang) begin
          if (p_cnt == 0) begin
            mem_done = 1'b1;
            pend = 1'b0;
            if (p_wr) begin
              mem_arr[p_addr] = p_data;
              mem_data_out = 16'h0000;
            end else begin
              mem_data_out = mem_val(p_addr);
            end
          end else begin
            p_cnt--;
          end
        end
      end
    end
  end

  task automatic wait_done(input bit isd, input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (((isd ? d_done : i_done) !== 1'b1) && (n < budget));
    chk1(isd ? "wait_d_done" : "wait_i_done", (isd ? d_done : i_done), 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int seen;
    rst = 1'b1; i_rd = 1'b0; i_addr = 16'h0000; d_rd = 1'b0; d_wr = 1'b0;
    d_addr = 16'h0000; d_data_in = 16'h0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("rst_mem_rd", mem_rd, 1'b0);
    chk1("rst_i_done", i_done, 1'b0);
    chk1("rst_d_done", d_done, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk16("rst_mem_addr", mem_addr, 16'h0000);
    chk16("rst_d_data_out", d_data_out, 16'h0000);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single fetch, memory answers in the first wait cycle.
    mem_lat = 1;
    mem_arr[16'h0010] = 16'h1234;
    push(1'b0, 1'b0, 16'h1234);
    @(posedge clk); #1;
    i_rd = 1'b1; i_addr = 16'h0010;
    @(negedge clk);
    chk1("t2_idle_mem_rd", mem_rd, 1'b0);
    chk1("t2_i_stall", i_stall, 1'b1);
    @(negedge clk);
    chk1("t2_issue_mem_rd", mem_rd, 1'b1);
    chk1("t2_issue_mem_wr", mem_wr, 1'b0);
    chk16("t2_issue_mem_addr", mem_addr, 16'h0010);
    @(negedge clk);
    chk1("t2_wait_mem_rd", mem_rd, 1'b0);
    chk16("t2_wait_mem_addr", mem_addr, 16'h0010);
    chk1("t2_wait_i_done", i_done, 1'b0);
    @(negedge clk);
    chk1("t2_done_cycle4", i_done, 1'b1);
    chk1("t2_done_i_stall", i_stall, 1'b0);
    chk16("t2_idle_mem_addr", mem_addr, 16'h0000);
    i_rd = 1'b0;
    @(negedge clk);
    chk1("t2_done_pulse_width", i_done, 1'b0);
    chk16("t2_i_data_hold", i_data_out, 16'h1234);
    repeat (2) @(negedge clk);

    // Simultaneous fetch and data write: data goes first.
    mem_arr[16'h0020] = 16'h2020;
    push(1'b1, 1'b1, 16'h0000);
    push(1'b0, 1'b0, 16'h2020);
    @(posedge clk); #1;
    i_rd = 1'b1; i_addr = 16'h0020;
    d_wr = 1'b1; d_addr = 16'h0200; d_data_in = 16'hBEEF;
    repeat (2) @(negedge clk);
    chk1("t3_mem_wr", mem_wr, 1'b1);
    chk1("t3_mem_rd", mem_rd, 1'b0);
    chk16("t3_mem_addr", mem_addr, 16'h0200);
    chk16("t3_mem_data_in", mem_data_in, 16'hBEEF);
    wait_done(1'b1, 20, n);
    d_wr = 1'b0;
    wait_done(1'b0, 20, n);
    i_rd = 1'b0;
    repeat (2) @(negedge clk);

    // Read back with a same-cycle hit, then a write that must not disturb d_data_out.
    mem_lat = 0;
    push(1'b1, 1'b0, 16'hBEEF);
    @(posedge clk); #1;
    d_rd = 1'b1; d_addr = 16'h0200;
    wait_done(1'b1, 20, n);
    chk16("t3_same_cycle_hit_latency", 16'(n), 16'd3);
    d_rd = 1'b0;
    repeat (2) @(negedge clk);
    mem_lat = 1;
    push(1'b1, 1'b1, 16'h0000);
    @(posedge clk); #1;
    d_wr = 1'b1; d_addr = 16'h0201; d_data_in = 16'h0F0F;
    wait_done(1'b1, 20, n);
    d_wr = 1'b0;
    repeat (2) @(negedge clk);

    // Starvation: four data grants, then fetch; the counter restarts so four more data grants follow.
    mem_arr[16'h0030] = 16'h3030;
    mem_arr[16'h0031] = 16'h3131;
    mem_arr[16'h0040] = 16'h4040;
    for (int k = 0; k < 4; k++) push(1'b1, 1'b0, 16'h4040);
    push(1'b0, 1'b0, 16'h3030);
    for (int k = 0; k < 4; k++) push(1'b1, 1'b0, 16'h4040);
    push(1'b0, 1'b0, 16'h3131);
    @(posedge clk); #1;
    i_rd = 1'b1; i_addr = 16'h0030; d_rd = 1'b1; d_addr = 16'h0040;
    for (int k = 0; k < 4; k++) wait_done(1'b1, 20, n);
    wait_done(1'b0, 20, n);
    i_addr = 16'h0031;
    for (int k = 0; k < 4; k++) wait_done(1'b1, 20, n);
    wait_done(1'b0, 20, n);
    i_rd = 1'b0; d_rd = 1'b0;
    repeat (3) @(negedge clk);

    // Fetch cancelled in its wait state; the pending data read is served afterwards.
    mem_lat = 3;
    mem_arr[16'h0060] = 16'h6060;
    push(1'b1, 1'b0, 16'h6060);
    @(posedge clk); #1;
    i_rd = 1'b1; i_addr = 16'h0050;
    repeat (3) @(negedge clk);
    chk1("t5_wait_mem_rd", mem_rd, 1'b0);
    chk16("t5_wait_mem_addr", mem_addr, 16'h0050);
    i_rd = 1'b0; d_rd = 1'b1; d_addr = 16'h0060;
    wait_done(1'b1, 30, n);
    d_rd = 1'b0;
    repeat (3) @(negedge clk);

    // Reset held two cycles during a data wait aborts it silently.
    mem_lat = 10;
    @(posedge clk); #1;
    d_rd = 1'b1; d_addr = 16'h0080;
    repeat (3) @(negedge clk);
    chk16("t1_wait_mem_addr", mem_addr, 16'h0080);
    rst = 1'b1; d_rd = 1'b0; last_d = 16'h0000;
    @(negedge clk);
    chk1("t1_rst_mem_rd", mem_rd, 1'b0);
    chk1("t1_rst_mem_wr", mem_wr, 1'b0);
    chk16("t1_rst_mem_addr", mem_addr, 16'h0000);
    chk16("t1_rst_mem_data_in", mem_data_in, 16'h0000);
    chk16("t1_rst_i_data_out", i_data_out, 16'h0000);
    chk16("t1_rst_d_data_out", d_data_out, 16'h0000);
    chk1("t1_rst_d_done", d_done, 1'b0);
    chk1("t1_rst_d_stall", d_stall, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (d_done === 1'b1) seen++;
    end
    chk16("t1_no_done_after_rst", 16'(seen), 16'd0);

    // Memory never answers: err after 64 wait cycles, back in IDLE.
    mem_hang = 1'b1;
    @(posedge clk); #1;
    d_rd = 1'b1; d_addr = 16'h0070;
    repeat (66) @(negedge clk);
    chk1("t6_err_before_timeout", err, 1'b0);
    chk16("t6_mem_addr_waiting", mem_addr, 16'h0070);
    @(negedge clk);
    chk1("t6_err_timeout", err, 1'b1);
    chk16("t6_mem_addr_idle", mem_addr, 16'h0000);
    chk1("t6_no_d_done", d_done, 1'b0);
    d_rd = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mem_hang = 1'b0;
    mem_lat = 1;
    chk1("t6_err_cleared_by_rst", err, 1'b0);

    // Read and write requested together flag err.
    @(posedge clk); #1;
    d_rd = 1'b1; d_wr = 1'b1; d_addr = 16'h0090; d_data_in = 16'h1111;
    @(negedge clk);
    chk1("t6_err_before_conflict", err, 1'b0);
    @(negedge clk);
    chk1("t6_err_conflict", err, 1'b1);
    d_rd = 1'b0; d_wr = 1'b0;
    repeat (6) @(negedge clk);
    chk1("t6_err_sticky", err, 1'b1);
    chk16("scoreboard_empty", 16'(sb.size()), 16'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
